// File: rtl/alu_pkg.sv
// Constants and types shared by the alu, its command sequencer and their benches.
package alu_pkg;

  localparam int WIDTH = 8;
  localparam int OPW   = 4;
  localparam int FLAGW = 5;
  localparam int SEQW  = 8;

  typedef enum logic [OPW-1:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
    OP_INC, OP_DEC, OP_NAND, OP_NOR, OP_XNOR, OP_PASSB, OP_ROL, OP_ROR
  } alu_op_e;

  // One queued result as it travels through the result FIFO.
  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic [FLAGW-1:0] flags;
    logic [SEQW-1:0]  seq;
  } res_entry_t;

  localparam int ENTRYW = $bits(res_entry_t);

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshakes of alu_cmd_sequencer; master is the command source/result sink.
interface alu_cmd_sequencer_if;
  import alu_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [OPW-1:0]   cmd_opcode;
  logic             cmd_use_acc;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_out;
  logic [FLAGW-1:0] res_flags;
  logic [SEQW-1:0]  res_seq;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_use_acc, res_ready,
    input  cmd_ready, res_valid, res_out, res_flags, res_seq
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_use_acc, res_ready,
    output cmd_ready, res_valid, res_out, res_flags, res_seq
  );

endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU. Flags are {parity(odd), overflow, negative, carry/borrow, zero}.
module alu
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  output logic [WIDTH-1:0] out,
  output logic [FLAGW-1:0] flags
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] wide;
  logic           carry;
  logic           ovf;

  always_comb begin
    wide  = '0;
    out   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (alu_op_e'(opcode))
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        out   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        out   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   out = a & b;
      OP_OR:    out = a | b;
      OP_XOR:   out = a ^ b;
      OP_NOT:   out = ~a;
      OP_SHL: begin
        out   = {a[WIDTH-2:0], 1'b0};
        carry = a[WIDTH-1];
      end
      OP_SHR: begin
        out   = {1'b0, a[WIDTH-1:1]};
        carry = a[0];
      end
      OP_INC: begin
        out   = a + WIDTH'(1);
        carry = &a;
        ovf   = (a == SMAX);
      end
      OP_DEC: begin
        out   = a - WIDTH'(1);
        carry = (a == '0);
        ovf   = (a == SMIN);
      end
      OP_NAND:  out = ~(a & b);
      OP_NOR:   out = ~(a | b);
      OP_XNOR:  out = ~(a ^ b);
      OP_PASSB: out = b;
      OP_ROL: begin
        out   = {a[WIDTH-2:0], a[WIDTH-1]};
        carry = a[WIDTH-1];
      end
      OP_ROR: begin
        out   = {a[0], a[WIDTH-1:1]};
        carry = a[0];
      end
      default: ;
    endcase
  end

  assign flags = {^out, ovf, out[WIDTH-1], carry, out == '0};

endmodule

// File: rtl/alu_res_fifo.sv
// Synchronous result FIFO with occupancy count; the head entry is read straight from storage.
module alu_res_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign valid   = (count != '0);
  assign rd_data = mem[rd_ptr];

  // Storage is cleared too so the result outputs read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !do_pop)      count <= count + CW'(1);
      else if (!push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Registered, flow-controlled front end for the alu: issue register, accumulator,
// sequence numbering, sticky flags and a result FIFO.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_cmd_sequencer_if.slave    bus,
  output logic [WIDTH-1:0]      acc,
  output logic [FLAGW-1:0]      flags_sticky,
  input  logic                  clr_sticky
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             ex_valid;
  logic             ex_use_acc;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [OPW-1:0]   ex_op;
  logic [SEQW-1:0]  seq_cnt;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_out;
  logic [FLAGW-1:0] alu_flags;
  logic             cmd_fire;
  logic             res_fire;
  res_entry_t       push_entry;
  res_entry_t       head_entry;

  // Reserving a slot for the instruction in execute keeps every push inside the FIFO.
  assign bus.cmd_ready = (int'(fifo_count) + int'(ex_valid)) < DEPTH;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign res_fire      = bus.res_valid && bus.res_ready;

  assign alu_a      = ex_use_acc ? acc : ex_a;
  assign push_entry = '{out: alu_out, flags: alu_flags, seq: seq_cnt};

  alu u_alu (
    .a      (alu_a),
    .b      (ex_b),
    .opcode (ex_op),
    .out    (alu_out),
    .flags  (alu_flags)
  );

  alu_res_fifo #(.W(ENTRYW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ex_valid),
    .push_data (push_entry),
    .pop       (res_fire),
    .rd_data   (head_entry),
    .valid     (bus.res_valid),
    .count     (fifo_count)
  );

  assign bus.res_out   = head_entry.out;
  assign bus.res_flags = head_entry.flags;
  assign bus.res_seq   = head_entry.seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_use_acc <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_op      <= '0;
    end else begin
      ex_valid <= cmd_fire;
      if (cmd_fire) begin
        ex_use_acc <= bus.cmd_use_acc;
        ex_a       <= bus.cmd_a;
        ex_b       <= bus.cmd_b;
        ex_op      <= bus.cmd_opcode;
      end
    end
  end

  // A clear coinciding with a result keeps only that result's flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      seq_cnt      <= '0;
      flags_sticky <= '0;
    end else begin
      if (ex_valid) begin
        acc     <= alu_out;
        seq_cnt <= seq_cnt + SEQW'(1);
      end
      if (clr_sticky)    flags_sticky <= ex_valid ? alu_flags : '0;
      else if (ex_valid) flags_sticky <= flags_sticky | alu_flags;
    end
  end

endmodule
